// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one RAM controller port between instruction fetch and the data unit.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_ready,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic              ram_busy,
    input  logic              ram_data_ready,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       we_r;
    logic       pick_data_s;

`ifdef MEM_ARB_RR_EN
    logic       last_data_r;

    // Round-robin winner: on a tie the requester that did not complete last wins
    always_comb begin
        pick_data_s = 1'b0;
        if (d_req && f_req) begin
            pick_data_s = ~last_data_r;
        end else begin
            pick_data_s = d_req;
        end
    end
`else
    // Fixed-priority winner: data over fetch
    always_comb begin
        pick_data_s = 1'b0;
        if (d_req) begin
            pick_data_s = 1'b1;
        end else begin
            pick_data_s = 1'b0;
        end
    end
`endif

    // Arbitration FSM with registered grants, strobes, completions and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            we_r      <= 1'b0;
            f_gnt     <= 1'b0;
            f_ready   <= 1'b0;
            f_rdata   <= {DATA_W{1'b0}};
            d_gnt     <= 1'b0;
            d_ready   <= 1'b0;
            d_rdata   <= {DATA_W{1'b0}};
            err       <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_wdata <= {DATA_W{1'b0}};
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_data_r <= 1'b0;
`endif
        end else begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            f_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
            case (state_r)
                IDLE: begin
                    // No arbitration while a completion pulse is out, so the finishing requester can drop req
                    if (!ram_busy && !f_ready && !d_ready) begin
                        if (f_gnt || d_gnt) begin
                            ram_read  <= ~we_r;
                            ram_write <= we_r;
                            state_r   <= ISSUE;
                        end else if (d_req || f_req) begin
                            if (pick_data_s) begin
                                d_gnt     <= 1'b1;
                                ram_addr  <= d_addr;
                                ram_wdata <= d_wdata;
                                we_r      <= d_we;
                                ram_read  <= ~d_we;
                                ram_write <= d_we;
                            end else begin
                                f_gnt     <= 1'b1;
                                ram_addr  <= f_addr;
                                ram_wdata <= {DATA_W{1'b0}};
                                we_r      <= 1'b0;
                                ram_read  <= 1'b1;
                                ram_write <= 1'b0;
                            end
                            state_r <= ISSUE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (ram_busy) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= 8'd0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (ram_data_ready || cnt_r == LAST_CNT) begin
                        if (f_gnt) begin
                            f_ready <= 1'b1;
                            if (!ram_data_ready) begin
                                f_rdata <= {DATA_W{1'b0}};
                            end else if (!we_r) begin
                                f_rdata <= ram_out;
                            end else begin
                                f_rdata <= f_rdata;
                            end
                        end else begin
                            d_ready <= 1'b1;
                            if (!ram_data_ready) begin
                                d_rdata <= {DATA_W{1'b0}};
                            end else if (!we_r) begin
                                d_rdata <= ram_out;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end
                        err     <= ~ram_data_ready;
                        f_gnt   <= 1'b0;
                        d_gnt   <= 1'b0;
                        cnt_r   <= cnt_r + 8'd1;
                        state_r <= IDLE;
`ifdef MEM_ARB_RR_EN
                        last_data_r <= d_gnt;
`endif
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single RAM controller port between instruction fetch and the data (load/store) unit. It grants the port to one requester at a time and drives the RAM strobes and address. It retries strobes rejected by `ram_busy`, returns read data or write completion to the owner, and aborts transactions the RAM never answers. It sits between the core's `fetch`/memory stage and the RAM controller, replacing the direct `addr_bus_mux_ctl` steering.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max WAIT cycles before abort (1..255; counter is 8 bits)

- `clk`  in  1  core clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `f_req`  in  1  fetch request; held with `f_addr` stable until `f_ready`
- `f_addr`  in  ADDR_W  fetch address
- `f_gnt`  out  1  fetch owns the port
- `f_ready`  out  1  one-cycle completion pulse to fetch
- `f_rdata`  out  DATA_W  fetched word; valid with `f_ready`, held until next fetch completion
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ready`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data unit owns the port
- `d_ready`  out  1  one-cycle completion pulse to data unit
- `d_rdata`  out  DATA_W  read data; valid with `d_ready`, held until next data completion
- `err`  out  1  pulses with `f_ready`/`d_ready` when the transaction timed out
- `ram_addr`  out  ADDR_W  registered RAM address
- `ram_wdata`  out  DATA_W  registered RAM write data
- `ram_read`  out  1  one-cycle read strobe
- `ram_write`  out  1  one-cycle write strobe
- `ram_busy`  in  1  RAM controller cannot accept a strobe
- `ram_data_ready`  in  1  one-cycle completion (read data valid on `ram_out`, or write done)
- `ram_out`  in  DATA_W  RAM read data

## Operation
- Reset: every output 0; state IDLE; owner = none; last-owner = fetch; timeout counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: if `ram_busy` = 1 or there are no requests, remain. Otherwise pick the winner, latch its address, write data and `we` into `ram_addr`/`ram_wdata`, set the owner's `gnt`, and set `ram_read` or `ram_write` for the next cycle. Next state is ISSUE.
- ISSUE: strobe high for exactly this cycle. If `ram_busy` = 1 in this cycle, the strobe is rejected: go to IDLE and keep `gnt`. The same owner is re-issued at the next non-busy IDLE cycle, with no re-arbitration. Otherwise go to WAIT and clear the counter.
- WAIT: strobes are 0; the counter increments each cycle.
  - `ram_data_ready` = 1: capture `ram_out` into the owner's rdata (reads only; writes leave rdata unchanged), pulse the owner's ready next cycle, drop `gnt`, and go to IDLE.
  - Counter reaches `TIMEOUT` without `ram_data_ready`: pulse the owner's ready and `err` together with rdata = 0, drop `gnt`, and go to IDLE.
- Arbitration without the macro: fixed priority, data over fetch.
- `ram_data_ready` seen in IDLE or ISSUE (stale response after a timeout or reset) is ignored.
- A requester dropping `req` mid-transaction does not cancel it; ready still pulses and the requester ignores it.
- `f_gnt` and `d_gnt` are never both 1.

## Timing
- Request sampled in IDLE at cycle N (RAM not busy) -> strobe at N+1 -> `ram_data_ready` at M -> ready/rdata at M+1.
- Minimum transaction: 4 cycles request-to-ready, when `ram_data_ready` arrives at N+2.
- Back-to-back: after a ready pulse the arbiter spends one IDLE cycle, then issues the next grant. No pipelining; at most one outstanding RAM transaction.
- A busy rejection costs 2 cycles per retry.
- Reset mid-transaction: all outputs go to 0 in the following cycle. The outstanding RAM transaction is abandoned and its late response is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a simultaneous request, the requester that is not last-owner wins; last-owner updates at each completion, including timeouts. Because last-owner resets to fetch, data wins the first tie.
- Undefined: fixed data-over-fetch priority; no last-owner register.

## Test plan
- Single fetch: `f_req`, `f_addr`=0x0010; RAM returns 0xDEADBEEF two cycles after the strobe -> one `ram_read` pulse with `ram_addr`=0x0010; `f_ready` at cycle 4 with `f_rdata`=0xDEADBEEF; `err`=0.
- Data write: `d_we`=1, `d_addr`=0x1234, `d_wdata`=0x0000ABCD -> one `ram_write` pulse with matching `ram_addr`/`ram_wdata`; `d_ready` pulses; `d_rdata` unchanged.
- Busy retry: `ram_busy`=1 during ISSUE for 3 attempts, then 0 -> 4 strobes total, same address each time; `f_gnt` held throughout; exactly one `f_ready`.
- Contention: `f_req` and `d_req` held for 4 transactions. Without the macro -> 4 data grants, 0 fetch. With `MEM_ARB_RR_EN` -> grants alternate D, F, D, F.
- Timeout: `TIMEOUT`=8, RAM never answers -> `d_ready` and `err` pulse exactly 9 cycles after the strobe, `d_rdata`=0. A `ram_data_ready` injected 2 cycles later is ignored.
- Reset in WAIT: assert `rst` for 1 cycle -> all outputs 0 next cycle. Later `ram_data_ready` produces no ready pulse; the next `f_req` is served normally.
